// File: rtl/seq_adder.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock, LSB chunk first, ripple carry between chunks.
// Define ADDER_FLAGS_EN to add registered zero and signed-overflow flags.
module seq_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
`ifdef ADDER_FLAGS_EN
  ,
  output logic             zero,
  output logic             ovf
`endif
);

  localparam int unsigned N     = WIDTH / CHUNK;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_op;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH-1:0] partial;
  logic [WIDTH-1:0] result_c;
  logic             carry;
  logic [IDX_W-1:0] idx;
  logic [CHUNK:0]   chunk_c;
  logic             load;
  logic             step;
  logic             last;
  int unsigned      lo;

  // One chunk of the ripple: current slice of both operands plus the running carry.
  always_comb begin
    lo       = 32'(idx) * CHUNK;
    chunk_c  = {1'b0, a_op[lo +: CHUNK]} + {1'b0, b_op[lo +: CHUNK]} + {{CHUNK{1'b0}}, carry};
    result_c = partial;
    result_c[lo +: CHUNK] = chunk_c[CHUNK-1:0];
    last     = (idx == IDX_W'(N - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // DONE accepts a new start just like IDLE, so operations can run back-to-back.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Subtraction is folded into the load: A - B - Cin == A + ~B + ~Cin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_op    <= '0;
      b_op    <= '0;
      partial <= '0;
      carry   <= 1'b0;
      idx     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      Sum     <= '0;
      Cout    <= 1'b0;
`ifdef ADDER_FLAGS_EN
      zero    <= 1'b0;
      ovf     <= 1'b0;
`endif
    end else begin
      busy <= (state_next == RUN);
      done <= (state_next == DONE);
      if (load) begin
        a_op    <= A;
        b_op    <= sub ? ~B : B;
        carry   <= sub ? ~Cin : Cin;
        idx     <= '0;
        partial <= '0;
      end else if (step) begin
        partial <= result_c;
        carry   <= chunk_c[CHUNK];
        idx     <= idx + 1'b1;
        if (last) begin
          Sum  <= result_c;
          Cout <= chunk_c[CHUNK];
`ifdef ADDER_FLAGS_EN
          zero <= (result_c == '0);
          ovf  <= (a_op[WIDTH-1] == b_op[WIDTH-1]) && (result_c[WIDTH-1] != a_op[WIDTH-1]);
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_adder.sv
// Randomised self-checking bench for seq_adder against an integer-arithmetic reference model.
module tb_seq_adder;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CHUNK = 4;
  localparam int unsigned N     = WIDTH / CHUNK;

  logic             clk   = 1'b0;
  logic             rst   = 1'b1;
  logic             start = 1'b0;
  logic             sub   = 1'b0;
  logic             cin   = 1'b0;
  logic [WIDTH-1:0] a     = '0;
  logic [WIDTH-1:0] b     = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef ADDER_FLAGS_EN
  logic             zero;
  logic             ovf;
`endif

  logic [WIDTH-1:0] exp_sum  = '0;
  logic             exp_cout = 1'b0;
  int               n_checks = 0;
  int               n_fail   = 0;

  always #5 clk = ~clk;

  seq_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .sub  (sub),
    .A    (a),
    .B    (b),
    .Cin  (cin),
    .busy (busy),
    .done (done),
    .Sum  (sum),
    .Cout (cout)
`ifdef ADDER_FLAGS_EN
    ,
    .zero (zero),
    .ovf  (ovf)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer add/subtract; overflow from the signed result range.
  function automatic void model(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                                input logic is, input logic ic,
                                output logic [WIDTH-1:0] s, output logic co,
                                output logic z, output logic ov);
    longint     sa, sb, r, max_s, min_s;
    logic [WIDTH:0] u;
    sa    = longint'($signed(ia));
    sb    = longint'($signed(ib));
    max_s = (longint'(1) << (WIDTH - 1)) - 1;
    min_s = -(longint'(1) << (WIDTH - 1));
    if (is) begin
      u  = {1'b0, ia} - {1'b0, ib} - (WIDTH+1)'(ic);
      co = ~u[WIDTH];
      r  = sa - sb - longint'(ic);
    end else begin
      u  = {1'b0, ia} + {1'b0, ib} + (WIDTH+1)'(ic);
      co = u[WIDTH];
      r  = sa + sb + longint'(ic);
    end
    s  = u[WIDTH-1:0];
    z  = (s == '0);
    ov = (r > max_s) || (r < min_s);
  endfunction

  // Called just after a negedge; returns at the negedge where done is seen.
  task automatic do_op(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                       input logic is, input logic ic, input bit meddle);
    logic [WIDTH-1:0] es;
    logic ec, ez, eo;
    int cyc;
    model(ia, ib, is, ic, es, ec, ez, eo);
    a = ia; b = ib; sub = is; cin = ic; start = 1'b1;
    @(negedge clk);
    cyc = 0;
    while (!done && cyc < 4 * N + 8) begin
      chk("busy_run", 32'(busy), 32'(1));
      chk("sum_hold", 32'(sum), 32'(exp_sum));
      chk("cout_hold", 32'(cout), 32'(exp_cout));
      start = meddle && (cyc == 0);
      a     = (meddle && cyc == 0) ? '1 : WIDTH'($urandom);
      b     = (meddle && cyc == 0) ? '1 : WIDTH'($urandom);
      sub   = 1'($urandom);
      cin   = 1'($urandom);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("latency", 32'(cyc), 32'(N));
    chk("done", 32'(done), 32'(1));
    chk("busy_at_done", 32'(busy), 32'(0));
    chk("sum", 32'(sum), 32'(es));
    chk("cout", 32'(cout), 32'(ec));
`ifdef ADDER_FLAGS_EN
    chk("zero", 32'(zero), 32'(ez));
    chk("ovf", 32'(ovf), 32'(eo));
`endif
    exp_sum  = es;
    exp_cout = ec;
  endtask

  task automatic idle_chk();
    @(negedge clk);
    chk("done_single", 32'(done), 32'(0));
    chk("busy_idle", 32'(busy), 32'(0));
    chk("sum_idle", 32'(sum), 32'(exp_sum));
  endtask

  initial begin
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_sum", 32'(sum), 32'(0));
    chk("rst_cout", 32'(cout), 32'(0));
    rst = 1'b0;

    do_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0);
    idle_chk();
    do_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    idle_chk();
    do_op(16'h0005, 16'h0007, 1'b1, 1'b0, 1'b0);
    idle_chk();
    do_op(16'h0007, 16'h0005, 1'b1, 1'b1, 1'b0);
    idle_chk();
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    idle_chk();
    do_op(16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0);
    idle_chk();
    do_op(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b1);
    idle_chk();

    // Abort two cycles into RUN: outputs clear at once and no done follows.
    a = 16'h00FF; b = 16'h0001; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre_rst_sum", 32'(sum), 32'(exp_sum));
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'(0));
    chk("arst_done", 32'(done), 32'(0));
    chk("arst_sum", 32'(sum), 32'(0));
    chk("arst_cout", 32'(cout), 32'(0));
`ifdef ADDER_FLAGS_EN
    chk("arst_zero", 32'(zero), 32'(0));
    chk("arst_ovf", 32'(ovf), 32'(0));
`endif
    exp_sum  = '0;
    exp_cout = 1'b0;
    @(negedge clk);
    chk("arst_no_done", 32'(done), 32'(0));
    rst = 1'b0;
    do_op(16'h0002, 16'h0003, 1'b0, 1'b0, 1'b0);
    idle_chk();

    for (int i = 0; i < 60; i++) begin
      do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 1) idle_chk();
    end
    idle_chk();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_adder.md
Name: seq_adder

Overview:
- Parametrised multi-cycle adder/subtractor that processes CHUNK bits per clock, LSB chunk first, with a ripple carry between chunks.
- Generalises the 8-bit combinational adder: width is a parameter, it adds a subtract mode, and it has a start/busy/done handshake.
- Used by the ALU datapath where a full-width single-cycle carry chain misses timing.

Parameters:
- WIDTH, 16, operand and result width; must be an integer multiple of CHUNK.
- CHUNK, 4, bits processed per cycle; N = WIDTH/CHUNK is the number of compute cycles.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled only when not busy.
- sub  input  1  0 = add, 1 = subtract; latched with start.
- A  input  WIDTH  operand A; latched with start.
- B  input  WIDTH  operand B; latched with start.
- Cin  input  1  carry-in (add) or borrow-in (sub); latched with start.
- busy  output  1  high while computing.
- done  output  1  one-cycle pulse when the result updates.
- Sum  output  WIDTH  registered result.
- Cout  output  1  registered carry-out; in sub mode, 1 = no borrow.
- zero  output  1  present only with ADDER_FLAGS_EN.
- ovf  output  1  present only with ADDER_FLAGS_EN.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset: state IDLE; busy=0, done=0, Sum=0, Cout=0, zero=0, ovf=0; internal operand, carry and chunk index registers cleared.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge k:
  - Latch A.
  - Latch Bop = sub ? ~B : B.
  - Set carry = sub ? ~Cin : Cin.
  - Set idx = 0; go to RUN.
- Arithmetic: sub computes A - B - Cin as A + ~B + ~Cin, modulo 2^WIDTH.
- RUN, each edge:
  - chunk[idx] = A[idx] + Bop[idx] + carry.
  - Low CHUNK bits go into the partial register; carry is updated; idx increments.
  - When idx = N-1 is processed, the edge transfers the partial result to Sum and the final carry to Cout, then goes to DONE.
- Latency: RUN occupies edges k+1..k+N. busy=1 for exactly N cycles, following edges k..k+N-1. done=1 for one cycle following edge k+N.
- Sum and Cout hold the previous result for the whole of RUN. They change only at the completion edge, then hold until the next completion or reset.
- DONE: done=1, busy=0. If start=1 in this cycle, it is accepted as in IDLE, giving back-to-back operation with no idle gap. Otherwise go to IDLE.
- start while busy=1 is ignored: no re-latch, no queueing. A, B, sub and Cin may change freely during RUN.
- rst asserted mid-RUN: abort immediately to reset values; no done pulse.
- CHUNK = WIDTH (N=1): RUN lasts one cycle; timing rules above still hold.

Optional Feature:
- Macro: ADDER_FLAGS_EN.
- Defined:
  - zero and ovf ports exist and are registered at the completion edge with Sum. Both reset to 0.
  - zero = (Sum == 0).
  - ovf = signed overflow. Add mode: A and B same sign, result sign differs. Sub mode: A and B signs differ, result sign differs from A.
- Undefined: zero and ovf ports and their logic are absent; all other behaviour is identical.

Test Plan (WIDTH=16, CHUNK=4):
- A=0x00FF, B=0x0001, Cin=0, add, start pulse -> busy high 4 cycles; done 4 cycles after start sample; Sum=0x0100, Cout=0.
- A=0xFFFF, B=0xFFFF, Cin=1, add -> Sum=0xFFFF, Cout=1. Then A=0xFFFF, B=0x0001, Cin=0, issued in the DONE cycle -> accepted back-to-back; Sum=0x0000, Cout=1; zero=1 with flags.
- sub, A=0x0005, B=0x0007, Cin=0 -> Sum=0xFFFE, Cout=0 (borrow). sub, A=0x0007, B=0x0005, Cin=1 -> Sum=0x0001, Cout=1.
- Start 0x1234+0x1111 -> during RUN, pulse start with A=0xFFFF, B=0xFFFF and change A -> ignored. Sum stays at its old value until completion, then 0x2345, Cout=0; exactly one done pulse.
- Start 0x00FF+0x0001, assert rst 2 cycles into RUN -> all outputs 0 immediately, no done pulse; after rst drops, the next op 0x0002+0x0003 gives 0x0005.
- With ADDER_FLAGS_EN: 0x7FFF+0x0001 add -> Sum=0x8000, ovf=1, zero=0. sub 0x8000-0x0001 -> Sum=0x7FFF, ovf=1.
